// File: rtl/alu_multicycle.sv
// Execution-stage ALU with a start/done handshake.
// Logic and arithmetic ops finish in one cycle. Shifts use an iterative
// 1-bit-per-cycle shifter, so a shift by N keeps the block busy for N cycles.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request, sampled only while idle
//   ALU_Sel  op code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
//            7 SLL, 8 SRL, 9 SRA, 10-15 reserved (Result = 0)
//   A, B     operands, captured when start is accepted; B[SHAMT_W-1:0] = shamt
//   busy     high while a multi-cycle shift is in progress
//   done     one-cycle pulse, Result/Zero valid from this cycle
//   Result   registered result, held until the next completion
//   Zero     registered (Result == 0)
module alu_multicycle #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ALU_Sel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  logic [0:0]         state_q,  state_d;
  logic [WIDTH-1:0]   shreg_q,  shreg_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]         op_q,     op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q,   zero_d;
  logic               done_q,   done_d;
  logic               busy_q,   busy_d;

  logic [SHAMT_W-1:0] shamt_c;
  logic               is_shift_c;
  logic [WIDTH-1:0]   alu_c;
  logic [WIDTH-1:0]   shift_step_c;

  assign shamt_c    = B[SHAMT_W-1:0];
  assign is_shift_c = (ALU_Sel == OP_SLL) || (ALU_Sel == OP_SRL) || (ALU_Sel == OP_SRA);

  // Single-cycle result; shifts only reach this path when shamt is zero.
  always_comb begin
    alu_c = '0;
    case (ALU_Sel)
      OP_ADD:  alu_c = A + B;
      OP_SUB:  alu_c = A - B;
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_XOR:  alu_c = A ^ B;
      OP_SLT:  alu_c = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: alu_c = WIDTH'(A < B);
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_c = A;
      default: alu_c = '0;
    endcase
  end

  // One-bit shift of the working register for the latched op.
  always_comb begin
    shift_step_c = shreg_q;
    case (op_q)
      OP_SLL:  shift_step_c = {shreg_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step_c = {1'b0, shreg_q[WIDTH-1:1]};
      OP_SRA:  shift_step_c = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shift_step_c = shreg_q;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_shift_c && (shamt_c != '0)) begin
            shreg_d = A;
            cnt_d   = shamt_c;
            op_d    = ALU_Sel;
            state_d = S_SHIFT;
          end else begin
            result_d = alu_c;
            zero_d   = (alu_c == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shift_step_c;
        cnt_d   = cnt_q - SHAMT_W'(1);
        // Last step: publish the final value, never an intermediate one.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shift_step_c;
          zero_d   = (shift_step_c == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// latency/result model of the ALU.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one operation may be outstanding.
  bit          m_inflight;
  int          m_left;
  logic [31:0] m_pend;
  logic [31:0] e_res;
  bit          e_done;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ALU_Sel (alu_sel),
    .A       (a),
    .B       (b),
    .busy    (busy),
    .done    (done),
    .Result  (result),
    .Zero    (zero)
  );

  function automatic logic [31:0] ref_result(input logic [3:0] op_sel,
                                             input logic [31:0] op_a,
                                             input logic [31:0] op_b);
    int unsigned sh = 32'(op_b[4:0]);
    case (op_sel)
      4'd0:    return op_a + op_b;
      4'd1:    return op_a - op_b;
      4'd2:    return op_a & op_b;
      4'd3:    return op_a | op_b;
      4'd4:    return op_a ^ op_b;
      4'd5:    return ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      4'd6:    return (op_a < op_b) ? 32'd1 : 32'd0;
      4'd7:    return op_a << sh;
      4'd8:    return op_a >> sh;
      4'd9:    return 32'($signed(op_a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-edge model update and output comparison.
  task automatic compare_loop();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_inflight = 1'b0;
        m_left     = 0;
        e_res      = 32'd0;
        e_done     = 1'b0;
      end else begin
        e_done = 1'b0;
        if (m_inflight) begin
          m_left--;
          if (m_left == 0) begin
            m_inflight = 1'b0;
            e_res      = m_pend;
            e_done     = 1'b1;
          end
        end else if (start) begin
          m_pend = ref_result(alu_sel, a, b);
          if ((alu_sel >= 4'd7) && (alu_sel <= 4'd9) && (b[4:0] != 5'd0)) begin
            m_inflight = 1'b1;
            m_left     = int'(b[4:0]);
          end else begin
            e_res  = m_pend;
            e_done = 1'b1;
          end
        end
      end
      #1;
      check("model_busy",   32'(busy), 32'(m_inflight));
      check("model_done",   32'(done), 32'(e_done));
      check("model_result", result,    e_res);
      check("model_zero",   32'(zero), 32'(e_res == 32'd0));
    end
  endtask

  // Caller is at a negedge. Issues one op and waits for done (bounded).
  // With poke set, a conflicting start is pulsed while the shift is busy.
  task automatic run_op(input logic [3:0] op_sel, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_busy, input bit poke,
                        input string name);
    int lat    = 0;
    int busy_n = 0;
    start   = 1'b1;
    alu_sel = op_sel;
    a       = op_a;
    b       = op_b;
    @(negedge clk);
    start   = 1'b0;
    alu_sel = 4'($urandom_range(0, 15));
    a       = $urandom;
    b       = $urandom;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
      if (poke && i == 2) begin
        start   = 1'b1;
        alu_sel = 4'd0;
        a       = $urandom;
        b       = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({name, "_result"}, result, exp_res);
    check({name, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    rst     = 1'b1;
    start   = 1'b0;
    alu_sel = 4'd0;
    a       = 32'd0;
    b       = 32'd0;
    fork
      compare_loop();
    join_none

    // Reset held for two edges.
    repeat (2) @(negedge clk);
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'd0);
    check("reset_zero",   32'(zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle ops, issued back to back.
    run_op(4'd0, 32'd5, 32'd7, 32'd12, 1, 0, 1'b0, "add");
    run_op(4'd1, 32'd3, 32'd3, 32'd0,  1, 0, 1'b0, "sub_b2b");
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0, 1'b0, "slt");
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1'b0, "sltu");
    run_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 0, 1'b0, "reserved");

    // Iterative shifts.
    run_op(4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 5, 4, 1'b0, "sra4");
    run_op(4'd8, 32'h8000_0000, 32'h24, 32'h0800_0000, 5, 4, 1'b0, "srl4");
    run_op(4'd7, 32'd1, 32'd31, 32'h8000_0000, 32, 31, 1'b0, "sll31");
    run_op(4'd7, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD, 1, 0, 1'b0, "sll0");

    // Start during busy is dropped; start in the done cycle is taken.
    run_op(4'd7, 32'd1, 32'd8, 32'h0000_0100, 9, 8, 1'b1, "sll8_poke");
    run_op(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1, 0, 1'b0, "xor_after_done");

    // Reset in the middle of an SRA aborts it with no done pulse.
    start   = 1'b1;
    alu_sel = 4'd9;
    a       = 32'h8000_0000;
    b       = 32'h0000_002A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_done_count", 32'(done_seen), 32'd0);
    check("abort_busy",       32'(busy), 32'd0);
    check("abort_result",     result,    32'd0);
    check("abort_zero",       32'(zero), 32'd1);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 249) == 0);
      start   = ($urandom_range(0, 2) != 0);
      alu_sel = 4'($urandom_range(0, 15));
      a       = pick_operand();
      b       = pick_operand();
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
